// File: rtl/goldschmidt_div_ctrl.sv
// Goldschmidt single-precision divider sequencer: special cases, operand prescale,
// 2-D factor generation and shared-multiplier time-slicing. Optional: GS_EARLY_EXIT_EN.
module goldschmidt_div_ctrl #(
  parameter int ITERS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic        div_by_zero,
  output logic        invalid,
  output logic        mul_req,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_ack,
  input  logic [31:0] mul_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESCALE, S_FACTOR, S_MUL_N, S_MUL_D, S_DONE
  } state_e;

  localparam logic [31:0] QNAN   = 32'h7FC00000;
  localparam logic [31:0] ONE    = 32'h3F800000;
  localparam logic [3:0]  ITERS_C = 4'(ITERS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] quotient_q, quotient_d;
  logic        dbz_q, dbz_d, inv_q, inv_d;
  logic        mul_req_q, mul_req_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [31:0] n_r_q, n_r_d, d_r_q, d_r_d, f_q, f_d;

  // F = 2 - D_r for D_r in [0.5, 1), rounded to nearest-even; D_r == 1.0 gives F == 1.0.
  function automatic logic [31:0] rnd_factor(input logic [30:0] d);
    logic [23:0] r;
    logic [22:0] m;
    if (d[30:23] != 8'd126) return ONE;
    r = 24'd0 - {1'b1, d[22:0]};
    m = r[23:1] + 23'(r[0] & r[1]);
    return {1'b0, 8'd127, m};
  endfunction

  logic              sgn_in, sgn_r;
  logic              n_zero, n_inf, n_nan, d_zero, d_inf, d_nan;
  logic signed [9:0] exp_w;
  logic [3:0]        cnt_nxt;
  logic              exit_now;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quotient_d = quotient_q;
    dbz_d      = dbz_q;
    inv_d      = inv_q;
    mul_req_d  = mul_req_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    n_r_d      = n_r_q;
    d_r_d      = d_r_q;
    f_d        = f_q;
    exit_now   = 1'b0;
    cnt_nxt    = cnt_q + 4'd1;

    sgn_in = dividend[31] ^ divisor[31];
    n_zero = (dividend[30:23] == 8'd0);
    n_inf  = (dividend[30:23] == 8'hFF) && (dividend[22:0] == 23'd0);
    n_nan  = (dividend[30:23] == 8'hFF) && (dividend[22:0] != 23'd0);
    d_zero = (divisor[30:23] == 8'd0);
    d_inf  = (divisor[30:23] == 8'hFF) && (divisor[22:0] == 23'd0);
    d_nan  = (divisor[30:23] == 8'hFF) && (divisor[22:0] != 23'd0);

    sgn_r = n_r_q[31] ^ d_r_q[31];
    exp_w = $signed({2'b00, n_r_q[30:23]}) - $signed({2'b00, d_r_q[30:23]}) + 10'sd126;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_r_d = dividend;
          d_r_d = divisor;
          dbz_d = 1'b0;
          inv_d = 1'b0;
          state_d = S_DONE;
          if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) begin
            quotient_d = QNAN;
            inv_d      = 1'b1;
          end else if (n_inf) begin
            quotient_d = {sgn_in, 8'hFF, 23'd0};
          end else if (d_zero) begin
            quotient_d = {sgn_in, 8'hFF, 23'd0};
            dbz_d      = 1'b1;
          end else if (n_zero || d_inf) begin
            quotient_d = {sgn_in, 31'd0};
          end else begin
            state_d = S_PRESCALE;
          end
        end
      end
      S_PRESCALE: begin
        d_r_d = {1'b0, 8'd126, d_r_q[22:0]};
        if (exp_w >= 10'sd255) begin
          quotient_d = {sgn_r, 8'hFF, 23'd0};
          state_d    = S_DONE;
        end else if (exp_w <= 10'sd0) begin
          quotient_d = {sgn_r, 31'd0};
          state_d    = S_DONE;
        end else begin
          n_r_d   = {sgn_r, exp_w[7:0], n_r_q[22:0]};
          cnt_d   = 4'd0;
          state_d = S_FACTOR;
        end
      end
      S_FACTOR: begin
        // Operands for the numerator product are registered here so they are stable on entry to MUL_N.
        f_d       = rnd_factor(d_r_q[30:0]);
        mul_req_d = 1'b1;
        mul_a_d   = n_r_q;
        mul_b_d   = rnd_factor(d_r_q[30:0]);
        state_d   = S_MUL_N;
      end
      S_MUL_N: begin
        if (mul_ack) begin
          n_r_d   = mul_y;
          mul_a_d = d_r_q;
          mul_b_d = f_q;
          state_d = S_MUL_D;
        end
      end
      S_MUL_D: begin
        if (mul_ack) begin
          d_r_d     = mul_y;
          cnt_d     = cnt_nxt;
          mul_req_d = 1'b0;
`ifdef GS_EARLY_EXIT_EN
          exit_now  = (cnt_nxt == ITERS_C) || (mul_y == ONE);
`else
          exit_now  = (cnt_nxt == ITERS_C);
`endif
          if (exit_now) begin
            quotient_d = n_r_q;
            state_d    = S_DONE;
          end else begin
            state_d = S_FACTOR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      quotient_q <= 32'd0;
      dbz_q      <= 1'b0;
      inv_q      <= 1'b0;
      mul_req_q  <= 1'b0;
      mul_a_q    <= 32'd0;
      mul_b_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quotient_q <= quotient_d;
      dbz_q      <= dbz_d;
      inv_q      <= inv_d;
      mul_req_q  <= mul_req_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
    end
  end

  // Working operands are pure data; their contents are meaningless until a division starts.
  always_ff @(posedge clk) begin
    n_r_q <= n_r_d;
    d_r_q <= d_r_d;
    f_q   <= f_d;
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;
  assign mul_req     = mul_req_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;

endmodule

// File: tb/tb_goldschmidt_div_ctrl.sv
// Bench for goldschmidt_div_ctrl: behavioural float multiplier with programmable wait,
// real-arithmetic reference divider, directed boundary cases plus random operands.
module tb_goldschmidt_div_ctrl;
  localparam int ITERS = 4;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero, invalid, mul_req;
  logic [31:0] quotient, mul_a, mul_b;
  logic        mul_ack = 1'b0;
  logic [31:0] mul_y = 32'd0;

  goldschmidt_div_ctrl #(.ITERS(ITERS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .div_by_zero(div_by_zero),
    .invalid(invalid), .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ack(mul_ack), .mul_y(mul_y)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Single <-> double conversion; a single*single product is exact in double.
  function automatic real f2d(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'd0});
    e = 11'(int'(x[30:23]) - 127 + 1023);
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] d2f(input real r);
    logic [63:0] b;
    logic [52:0] sig;
    logic [24:0] rnd;
    logic [28:0] rem;
    int          e;
    b = $realtobits(r);
    if (b[62:0] == 63'd0) return {b[63], 31'd0};
    e   = int'(b[62:52]) - 1023 + 127;
    sig = {1'b1, b[51:0]};
    rnd = {1'b0, sig[52:29]};
    rem = sig[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && rnd[0])) rnd = rnd + 25'd1;
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e++;
    end
    if (e >= 255) return {b[63], 8'hFF, 23'd0};
    if (e <= 0) return {b[63], 31'd0};
    return {b[63], 8'(e), rnd[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return d2f(f2d(a) * f2d(b));
  endfunction

  // path: 0 = resolved at start, 1 = resolved at prescale, 2 = iterated `it` times.
  task automatic ref_div(input logic [31:0] n, input logic [31:0] d, output logic [31:0] q,
                         output logic dbz, output logic inv, output int path, output int it);
    logic s, nz, ninf, nnan, dz, dinf, dnan;
    logic [31:0] nr, dr, f;
    int e;
    s    = n[31] ^ d[31];
    nz   = n[30:23] == 8'd0;
    ninf = n[30:23] == 8'hFF && n[22:0] == 23'd0;
    nnan = n[30:23] == 8'hFF && n[22:0] != 23'd0;
    dz   = d[30:23] == 8'd0;
    dinf = d[30:23] == 8'hFF && d[22:0] == 23'd0;
    dnan = d[30:23] == 8'hFF && d[22:0] != 23'd0;
    dbz = 1'b0; inv = 1'b0; path = 0; it = 0;
    if (nnan || dnan || (nz && dz) || (ninf && dinf)) begin
      q = 32'h7FC00000; inv = 1'b1;
    end else if (ninf) begin
      q = {s, 8'hFF, 23'd0};
    end else if (dz) begin
      q = {s, 8'hFF, 23'd0}; dbz = 1'b1;
    end else if (nz || dinf) begin
      q = {s, 31'd0};
    end else begin
      path = 1;
      e = int'(n[30:23]) - int'(d[30:23]) + 126;
      if (e >= 255) q = {s, 8'hFF, 23'd0};
      else if (e <= 0) q = {s, 31'd0};
      else begin
        path = 2;
        nr = {s, 8'(e), n[22:0]};
        dr = {1'b0, 8'd126, d[22:0]};
        for (int i = 0; i < ITERS; i++) begin
          f  = d2f(2.0 - f2d(dr));
          nr = fmul(nr, f);
          dr = fmul(dr, f);
          it++;
`ifdef GS_EARLY_EXIT_EN
          if (dr == 32'h3F800000) break;
`endif
        end
        q = nr;
      end
    end
  endtask

  // Multiplier model: acks after mul_delay waiting cycles, checks operands hold while waiting.
  int          mul_delay = 0;
  int          wait_cnt = 0;
  logic        pending = 1'b0;
  logic [31:0] held_a, held_b;
  int          hs_count = 0;
  int          req_cycles = 0;

  task automatic mul_step();
    if (!rst_n || !mul_req) begin
      pending = 1'b0;
      mul_ack = 1'b0;
    end else begin
      req_cycles++;
      if (pending) begin
        chk("mul_a_hold", mul_a, held_a);
        chk("mul_b_hold", mul_b, held_b);
      end else begin
        wait_cnt = 0;
        held_a = mul_a;
        held_b = mul_b;
      end
      if (wait_cnt >= mul_delay) begin
        mul_ack = 1'b1;
        mul_y   = fmul(mul_a, mul_b);
        pending = 1'b0;
        hs_count++;
      end else begin
        mul_ack = 1'b0;
        wait_cnt++;
        pending = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mul_step();
  end

  task automatic run_div(input logic [31:0] n, input logic [31:0] d, input int delay,
                         input int poke_k, input string tag,
                         output logic [31:0] q_out, output int lat_out);
    logic [31:0] eq;
    logic edbz, einv;
    int path, it, exp_lat, k, hs0, rq0;
    ref_div(n, d, eq, edbz, einv, path, it);
    exp_lat = (path == 0) ? 0 : (path == 1) ? 1 : 1 + 3 * it + 2 * it * delay;
    mul_delay = delay;
    @(negedge clk);
    dividend = n; divisor = d; start = 1'b1;
    hs0 = hs_count; rq0 = req_cycles;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 400) begin
      if (k == poke_k) begin
        start = 1'b1; dividend = 32'h41200000; divisor = 32'h40000000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_flags"}, {30'd0, div_by_zero, invalid}, {30'd0, edbz, einv});
    chk({tag, "_hs"}, 32'(hs_count - hs0), 32'(2 * it));
    chk({tag, "_reqcyc"}, 32'(req_cycles - rq0), 32'(2 * it * (1 + delay)));
    q_out = quotient;
    lat_out = k;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  logic [31:0] q;
  int lat;
  logic [31:0] specials [6] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                               32'hFF800000, 32'h7FC00000, 32'h3F800000};

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saw;
    logic [31:0] rn, rd;
    rst_n = 1'b0; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {28'd0, busy, done, mul_req, div_by_zero}, 32'd0);
    chk("rst_inv", {31'd0, invalid}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_mul_a", mul_a, 32'd0);
    chk("rst_mul_b", mul_b, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run_div(32'h40C00000, 32'h40400000, 0, -1, "six_three", q, lat);
    chk("six_three_const", q, 32'h40000000);
    chk("six_three_edge", 32'(lat), 32'(1 + 3 * ITERS));

    run_div(32'h3F800000, 32'h40400000, 0, -1, "third", q, lat);
    chk("third_ulp", {31'd0, (int'(q) - int'(32'h3EAAAAAB) >= -1) && (int'(q) - int'(32'h3EAAAAAB) <= 1)}, 32'd1);
    run_div(32'h3F800000, 32'h40400000, 3, -1, "third_wait", q, lat);
    chk("third_ulp_wait", {31'd0, (int'(q) - int'(32'h3EAAAAAB) >= -1) && (int'(q) - int'(32'h3EAAAAAB) <= 1)}, 32'd1);

    run_div(32'h40A00000, 32'h00000000, 0, -1, "five_zero", q, lat);
    chk("five_zero_const", {q[31:0]}, 32'h7F800000);
    run_div(32'h00000000, 32'h80000000, 0, -1, "zero_zero", q, lat);
    chk("zero_zero_const", q, 32'h7FC00000);
    run_div(32'h7F000000, 32'h00800001, 0, -1, "exp_ovf", q, lat);
    chk("exp_ovf_const", q, 32'h7F800000);
    run_div(32'h00800000, 32'h3F800000, 0, -1, "exp_flush", q, lat);
    chk("exp_flush_const", q, 32'h00000000);
    run_div(32'h01000000, 32'h3F800000, 1, -1, "exp_min", q, lat);
    run_div(32'hC0C00000, 32'h40400000, 0, -1, "neg_six", q, lat);
    run_div(32'h7F800000, 32'hFF800000, 0, -1, "inf_inf", q, lat);
    run_div(32'hFF800000, 32'h40000000, 0, -1, "inf_two", q, lat);
    run_div(32'h40400000, 32'hFF800000, 0, -1, "three_inf", q, lat);
    run_div(32'h80000000, 32'h40A00000, 0, -1, "negzero", q, lat);
    run_div(32'h7FC00001, 32'h3F800000, 0, -1, "nan_in", q, lat);

    run_div(32'h40C00000, 32'h40400000, 0, 2, "busy_start", q, lat);
    chk("busy_start_const", q, 32'h40000000);

    // Reset during the denominator product.
    @(negedge clk);
    dividend = 32'h40C00000; divisor = 32'h40400000; start = 1'b1; mul_delay = 0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {28'd0, busy, done, mul_req, div_by_zero}, 32'd0);
    chk("midrst_inv", {31'd0, invalid}, 32'd0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_mul_a", mul_a, 32'd0);
    chk("midrst_mul_b", mul_b, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    saw = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) saw++;
    end
    chk("midrst_no_done", 32'(saw), 32'd0);
    run_div(32'h40C00000, 32'h40400000, 0, -1, "after_rst", q, lat);
    chk("after_rst_const", q, 32'h40000000);

    for (int i = 0; i < 40; i++) begin
      rn = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      rd = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) rn = specials[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) rd = specials[$urandom_range(0, 5)];
      run_div(rn, rd, int'($urandom_range(0, 2)), -1, "rand", q, lat);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
